// File: rtl/regfile_result_checker_pkg.sv
// regfile_result_checker_pkg: shared FSM encoding and width helpers for the result checker
package regfile_result_checker_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CHECK, ST_DONE} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
        return r;
    endfunction

    function automatic int max1(input int v);
        return v < 1 ? 1 : v;
    endfunction

endpackage

// File: rtl/regfile_result_checker_if.sv
// regfile_result_checker_if: control, expected table, register-file read port and result bundle
interface regfile_result_checker_if import regfile_result_checker_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_CHECKS = 4
);
    localparam int CW = clog2(NUM_CHECKS + 1);
    localparam int FW = max1(clog2(NUM_CHECKS));

    logic                         start;
    logic [NUM_CHECKS*ADDR_W-1:0] exp_addr;
    logic [NUM_CHECKS*WIDTH-1:0]  exp_data;
    logic [ADDR_W-1:0]            rd_addr;
    logic [WIDTH-1:0]             rd_data;
    logic                         busy;
    logic                         done;
    logic                         pass;
    logic [CW-1:0]                err_count;
    logic [FW-1:0]                fail_idx;
    logic [WIDTH-1:0]             fail_actual;

    modport master (
        input  start, exp_addr, exp_data, rd_data,
        output rd_addr, busy, done, pass, err_count, fail_idx, fail_actual
    );

    modport slave (
        output start, exp_addr, exp_data, rd_data,
        input  rd_addr, busy, done, pass, err_count, fail_idx, fail_actual
    );
endinterface

// File: rtl/regfile_result_checker_settle_counter.sv
// settle_counter: loadable down-counter with a zero flag, counts only while enabled
module settle_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;

    assign zero = cnt == '0;

    always_ff @(posedge clk) begin
        if (!reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && !zero) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/regfile_result_checker.sv
// regfile_result_checker: after a settle delay, reads back register-file entries and compares them
module regfile_result_checker import regfile_result_checker_pkg::*; #(
    parameter int WIDTH        = 32,
    parameter int ADDR_W       = 5,
    parameter int NUM_CHECKS   = 4,
    parameter int WAIT_CYCLES  = 50,
    parameter int STOP_ON_FAIL = 1
) (
    input logic                      clk,
    input logic                      reset,
    regfile_result_checker_if.master bus
);
    localparam int IXW = clog2(NUM_CHECKS + 1);
    localparam int FW  = max1(clog2(NUM_CHECKS));
    localparam int KW  = max1(clog2(WAIT_CYCLES));
    localparam logic [IXW-1:0] NC   = IXW'(NUM_CHECKS);
    localparam logic [KW-1:0]  LOAD = KW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    state_t            state, nxt;
    logic [IXW-1:0]    idx;
    logic [FW-1:0]     sel;
    logic [IXW-1:0]    err_count;
    logic [FW-1:0]     fail_idx;
    logic [WIDTH-1:0]  fail_actual;
    logic              go, active, mis, zero;
    logic [ADDR_W-1:0] addr_tab [NUM_CHECKS];
    logic [WIDTH-1:0]  data_tab [NUM_CHECKS];

    for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_tab
        assign addr_tab[i] = bus.exp_addr[i*ADDR_W +: ADDR_W];
        assign data_tab[i] = bus.exp_data[i*WIDTH +: WIDTH];
    end

    // Loaded with WAIT_CYCLES-1 so the zero flag marks the last WAIT cycle
    settle_counter #(.W(KW)) u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (go),
        .en       (state == ST_WAIT),
        .load_val (LOAD),
        .zero     (zero)
    );

    // idx runs one past the table: that final CHECK cycle compares nothing and closes the run
    always_comb begin
        go     = bus.start && (state == ST_IDLE || state == ST_DONE);
        active = state == ST_CHECK && idx != NC;
        sel    = active ? idx[FW-1:0] : '0;
        mis    = active && bus.rd_data != data_tab[sel];
        nxt    = state;
        if (go) nxt = WAIT_CYCLES == 0 ? ST_CHECK : ST_WAIT;
        else if (state == ST_WAIT && zero) nxt = ST_CHECK;
        else if (state == ST_CHECK && (!active || (mis && STOP_ON_FAIL != 0))) nxt = ST_DONE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            err_count   <= '0;
            fail_idx    <= '0;
            fail_actual <= '0;
        end else begin
            state <= nxt;
            if (go) begin
                idx         <= '0;
                err_count   <= '0;
                fail_idx    <= '0;
                fail_actual <= '0;
            end else if (active) begin
                idx <= idx + 1'b1;
                if (mis) begin
                    err_count <= err_count + 1'b1;
                    if (err_count == '0) begin
                        fail_idx    <= sel;
                        fail_actual <= bus.rd_data;
                    end
                end
            end
        end
    end

    assign bus.rd_addr     = active ? addr_tab[sel] : '0;
    assign bus.busy        = state == ST_WAIT || state == ST_CHECK;
    assign bus.done        = state == ST_DONE;
    assign bus.pass        = state == ST_DONE && err_count == '0;
    assign bus.err_count   = err_count;
    assign bus.fail_idx    = fail_idx;
    assign bus.fail_actual = fail_actual;
endmodule

// File: tb/tb_regfile_result_checker.sv
// tb_regfile_result_checker: scoreboard bench over three checker configurations sharing one register file
module tb_regfile_result_checker;
    logic        clk = 0;
    logic        reset = 0;
    logic [31:0] regs [32];
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          lat;
        logic        pass;
        int          err;
        int          fidx;
        logic [31:0] fact;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    regfile_result_checker_if #(.WIDTH(32), .ADDR_W(5), .NUM_CHECKS(4)) b0 ();
    regfile_result_checker_if #(.WIDTH(32), .ADDR_W(5), .NUM_CHECKS(4)) b1 ();
    regfile_result_checker_if #(.WIDTH(32), .ADDR_W(5), .NUM_CHECKS(1)) b2 ();

    regfile_result_checker #(.WIDTH(32), .ADDR_W(5), .NUM_CHECKS(4), .WAIT_CYCLES(50), .STOP_ON_FAIL(1))
        dut0 (.clk(clk), .reset(reset), .bus(b0));
    regfile_result_checker #(.WIDTH(32), .ADDR_W(5), .NUM_CHECKS(4), .WAIT_CYCLES(50), .STOP_ON_FAIL(0))
        dut1 (.clk(clk), .reset(reset), .bus(b1));
    regfile_result_checker #(.WIDTH(32), .ADDR_W(5), .NUM_CHECKS(1), .WAIT_CYCLES(0), .STOP_ON_FAIL(1))
        dut2 (.clk(clk), .reset(reset), .bus(b2));

    assign b0.rd_data = regs[b0.rd_addr];
    assign b1.rd_data = regs[b1.rd_addr];
    assign b2.rd_data = regs[b2.rd_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic set_start(input int d, input logic v);
        case (d)
            0:       b0.start = v;
            1:       b1.start = v;
            default: b2.start = v;
        endcase
    endtask

    task automatic observe(input int d, output logic bz, output logic dn, output logic ps,
                           output int er, output int fi, output logic [31:0] fa, output logic [31:0] ra);
        case (d)
            0: begin
                bz = b0.busy; dn = b0.done; ps = b0.pass; er = int'(b0.err_count);
                fi = int'(b0.fail_idx); fa = b0.fail_actual; ra = 32'(b0.rd_addr);
            end
            1: begin
                bz = b1.busy; dn = b1.done; ps = b1.pass; er = int'(b1.err_count);
                fi = int'(b1.fail_idx); fa = b1.fail_actual; ra = 32'(b1.rd_addr);
            end
            default: begin
                bz = b2.busy; dn = b2.done; ps = b2.pass; er = int'(b2.err_count);
                fi = int'(b2.fail_idx); fa = b2.fail_actual; ra = 32'(b2.rd_addr);
            end
        endcase
    endtask

    task automatic check_idle(input string tag, input int d);
        logic bz, dn, ps;
        int er, fi;
        logic [31:0] fa, ra;
        observe(d, bz, dn, ps, er, fi, fa, ra);
        check_val({tag, ".busy"}, 32'(bz), 0);
        check_val({tag, ".done"}, 32'(dn), 0);
        check_val({tag, ".pass"}, 32'(ps), 0);
        check_val({tag, ".err"}, er, 0);
        check_val({tag, ".fidx"}, fi, 0);
        check_val({tag, ".fact"}, fa, 0);
        check_val({tag, ".rd_addr"}, ra, 0);
    endtask

    // Pushes the expectation, pulses start, then pops and compares once done rises
    task automatic run(input string tag, input int d, input int lat, input logic ps_e, input int er_e,
                       input int fi_e, input logic [31:0] fa_e, input bit poke, input logic [31:0] ra0);
        exp_t e;
        logic bz, dn, ps;
        int er, fi, m;
        logic [31:0] fa, ra;
        bit got;
        sb.push_back('{lat, ps_e, er_e, fi_e, fa_e});
        @(negedge clk);
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        observe(d, bz, dn, ps, er, fi, fa, ra);
        check_val({tag, ".busy0"}, 32'(bz), 1);
        check_val({tag, ".done0"}, 32'(dn), 0);
        check_val({tag, ".err0"}, er, 0);
        check_val({tag, ".rd_addr0"}, ra, ra0);
        if (poke) set_start(d, 1'b1);
        m = 0;
        got = 0;
        while (m < 300 && !got) begin
            @(negedge clk);
            set_start(d, 1'b0);
            m++;
            observe(d, bz, dn, ps, er, fi, fa, ra);
            got = dn;
        end
        e = sb.pop_front();
        check_val({tag, ".latency"}, got ? m : -1, e.lat);
        check_val({tag, ".pass"}, 32'(ps), 32'(e.pass));
        check_val({tag, ".err"}, er, e.err);
        check_val({tag, ".fidx"}, fi, e.fidx);
        check_val({tag, ".fact"}, fa, e.fact);
        check_val({tag, ".busy_end"}, 32'(bz), 0);
    endtask

    initial begin
        logic bz, dn, ps;
        int er, fi;
        logic [31:0] fa, ra;
        for (int i = 0; i < 32; i++) regs[i] = 32'hdead_0000 + i;
        regs[2] = 32'h37; regs[4] = 32'hb; regs[8] = 32'hb; regs[9] = 32'h37;
        b0.start = 0; b1.start = 0; b2.start = 0;
        b0.exp_addr = {5'd9, 5'd8, 5'd4, 5'd2};
        b0.exp_data = {32'h37, 32'hb, 32'hb, 32'h37};
        b1.exp_addr = b0.exp_addr;
        b1.exp_data = b0.exp_data;
        b2.exp_addr = 5'd2;
        b2.exp_data = 32'h37;

        repeat (3) @(negedge clk);
        check_idle("reset0", 0);
        check_idle("reset2", 2);
        reset = 1;

        run("addn_pass", 0, 55, 1, 0, 0, 0, 0, 0);
        regs[4] = 32'hc;
        run("stop_fail", 0, 52, 0, 1, 1, 32'hc, 0, 0);
        regs[4] = 32'hb;
        run("restart", 0, 55, 1, 0, 0, 0, 0, 0);

        regs[4] = 32'hc; regs[9] = 32'h36;
        run("multi_fail", 1, 55, 0, 2, 1, 32'hc, 0, 0);
        regs[4] = 32'hb; regs[9] = 32'h37;

        run("nowait", 2, 2, 1, 0, 0, 0, 1, 2);
        repeat (2) begin
            @(negedge clk);
            observe(2, bz, dn, ps, er, fi, fa, ra);
            check_val("nowait.hold_done", 32'(dn), 1);
            check_val("nowait.hold_busy", 32'(bz), 0);
        end

        @(negedge clk);
        b0.start = 1;
        @(negedge clk);
        b0.start = 0;
        repeat (9) @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1;
        check_idle("mid_reset", 0);
        run("after_reset", 0, 55, 1, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
